// File: rtl/stream_minmax_tracker.sv
// stream_minmax_tracker
// Frame-based running max/min tracker built around one external combinational
// 8-bit comparator. Every ordering decision is taken from the comparator
// flags; no magnitude compare is done here. One {max, min, ties} result is
// presented per frame of FRAME_LEN samples.
module stream_minmax_tracker #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       cmp_a,
  output logic [7:0]       cmp_b,
  input  logic             cmp_agb,
  input  logic             cmp_bga,
  input  logic             cmp_aeb,
  output logic [7:0]       out_max,
  output logic [7:0]       out_min,
  output logic [CNT_W-1:0] out_ties,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             cmp_err
);

  localparam int unsigned DATA_W = 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPT    = 3'd1;
  localparam logic [2:0] S_CMP_MAX = 3'd2;
  localparam logic [2:0] S_CMP_MIN = 3'd3;
  localparam logic [2:0] S_OUT     = 3'd4;

  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] ONE_CNT     = CNT_W'(1);
  localparam logic             SINGLE_SAMP = (FRAME_LEN == 32'd1);

  logic [2:0]        state_q,  state_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [DATA_W-1:0] max_q,    max_d;
  logic [DATA_W-1:0] min_q,    min_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [CNT_W-1:0]  ties_q,   ties_d;
  logic              err_q,    err_d;

  logic [2:0]        flags_c;
  logic              flags_onehot_c;
  logic [CNT_W-1:0]  cnt_inc_c;

  // Flag legality: exactly one of AgB/BgA/AeB must be asserted during a compare
  always_comb begin
    flags_c = {cmp_agb, cmp_bga, cmp_aeb};
    flags_onehot_c = 1'b0;
    case (flags_c)
      3'b100, 3'b010, 3'b001: flags_onehot_c = 1'b1;
      default:                flags_onehot_c = 1'b0;
    endcase
  end

  assign cnt_inc_c = cnt_q + ONE_CNT;

  // Next-state and datapath update logic
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    max_d    = max_q;
    min_d    = min_q;
    cnt_d    = cnt_q;
    ties_d   = ties_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          max_d   = in_data;
          min_d   = in_data;
          cnt_d   = ONE_CNT;
          ties_d  = '0;
          state_d = SINGLE_SAMP ? S_OUT : S_CAPT;
        end
      end
      S_CAPT: begin
        if (in_valid) begin
          sample_d = in_data;
          state_d  = S_CMP_MAX;
        end
      end
      S_CMP_MAX: begin
        if (cmp_agb) max_d = sample_q;
        if (cmp_aeb) ties_d = ties_q + ONE_CNT;
        if (!flags_onehot_c) err_d = 1'b1;
        state_d = S_CMP_MIN;
      end
      S_CMP_MIN: begin
        if (cmp_bga) min_d = sample_q;
        if (!flags_onehot_c) err_d = 1'b1;
        cnt_d   = cnt_inc_c;
        state_d = (cnt_inc_c == LAST_CNT) ? S_OUT : S_CAPT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sample_q <= '0;
      max_q    <= '0;
      min_q    <= '0;
      cnt_q    <= '0;
      ties_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      max_q    <= max_d;
      min_q    <= min_d;
      cnt_q    <= cnt_d;
      ties_q   <= ties_d;
      err_q    <= err_d;
    end
  end

  // Handshake and result outputs decoded from registered state
  assign in_ready  = (state_q == S_IDLE) || (state_q == S_CAPT);
  assign out_valid = (state_q == S_OUT);
  assign out_max   = max_q;
  assign out_min   = min_q;
  assign out_ties  = ties_q;
  assign cmp_err   = err_q;

  // Comparator operand mux: B follows min only while comparing against min
  assign cmp_a = sample_q;
  assign cmp_b = (state_q == S_CMP_MIN) ? min_q : max_q;

endmodule
